pwm_timer_multi: RTL and testbench
==================================

# pwm_timer_multi

Multi-channel PWM timer: one shared counter, one shared period and `CHANNELS` independent compare channels. It adds edge- or center-aligned counting, one-shot or continuous runs, pause, and per-channel output polarity. Period and compare values are double-buffered and take effect only at a period boundary. It drives display-multiplexing and brightness PWM outputs from a single timebase.

## Interface
- `WIDTH`, 24: counter, period and compare width.
- `CHANNELS`, 4: number of compare/flag channels (≥1).
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: level sampled per cycle; launches a run from IDLE; ignored in RUN.
- `stop` in 1: synchronous abort to IDLE; priority over everything but `rst`.
- `en` in 1: count enable; 0 pauses the counter in RUN.
- `center` in 1: 0 = edge-aligned, 1 = center-aligned; latched at start.
- `oneshot` in 1: 1 = stop after one period; latched at start.
- `period` in WIDTH: live period P, sampled at start and at each period end.
- `compare` in CHANNELS*WIDTH: channel i uses bits [i*WIDTH +: WIDTH]; sampled with `period`.
- `pol` in CHANNELS: live per-channel invert.
- `tmr_count` out WIDTH: current count.
- `flag` out CHANNELS: PWM outputs.
- `wrap` out 1: 1-cycle pulse for each completed period.
- `done` out 1: 1-cycle pulse when a one-shot run ends.
- `busy` out 1: 1 while in RUN.

## Operation
- States: IDLE, RUN. `rst` forces IDLE with `tmr_count`=0, per_act=0, all cmp_act=0, dir=up, `wrap`=`done`=0, and `busy`=0.
- IDLE: counter holds 0.
  - `flag[i]` = `pol[i]` (inactive level).
  - On `start`=1 and `stop`=0: per_act←`period`, cmp_act[i]←`compare` slice, latch mode bits, `tmr_count`←0, dir←up, go to RUN.
- RUN with `en`=0: all registers hold. `flag` keeps following the held count.
- RUN with `en`=1, edge mode:
  - If `tmr_count`==per_act: end-of-period (EOP).
  - Otherwise `tmr_count`+1.
- RUN with `en`=1, center mode:
  - Up and `tmr_count`==per_act: EOP if per_act≤1; otherwise dir←down and count←per_act−1.
  - Up otherwise: +1.
  - Down and `tmr_count`==1: EOP.
  - Down otherwise: −1.
- EOP actions:
  - `tmr_count`←0, dir←up.
  - per_act and cmp_act reload from the live inputs.
  - If oneshot latched, go to IDLE.
- Period length in enabled cycles:
  - Edge mode: P+1.
  - Center mode: 2P for P≥1, and 1 for P=0.
- In RUN, `flag[i]` = (cmp_act[i] > `tmr_count`) XOR `pol[i]`. It is combinational from registers with an unsigned compare.
  - cmp_act=0 gives always inactive.
  - cmp_act>P gives always active.
- The counter never exceeds per_act, so there is no overflow. P = 2^WIDTH−1 is legal.
- `stop` in RUN: go to IDLE next cycle, no `wrap`, no `done`, shadows untouched.
- `start` and `stop` together in IDLE: stay in IDLE.
- `rst` mid-run returns to the reset values above. `tmr_count` is 0 in the next cycle.

## Timing
- Start latency: `start` sampled at edge k. At k+1, `busy`=1 and `tmr_count`=0. Count 1 appears at k+2 if `en`=1.
- `wrap`: registered, high for exactly the one cycle after an EOP edge, i.e. while `tmr_count`=0 holds the newly reloaded values. Never high in IDLE except that cycle after a one-shot EOP.
- `done`: coincides with the final `wrap` of a one-shot run. `busy` is 0 in that same cycle.
- Input changes to `period`/`compare` mid-period have no effect until the next EOP.
- Changes to `pol` take effect combinationally, with no latency.
- P=0 in continuous mode: `wrap` is high on every enabled cycle after the first.

## Test plan
- Edge, continuous, P=9, compare ch0=3, `pol`=0, `en`=1 → count 0..9 repeating. `flag[0]` high for counts 0–2 (3 of 10 cycles). `wrap` every 10 cycles.
- Center, P=4, compare ch1=2 → count 0,1,2,3,4,3,2,1,0… (8-cycle period). `flag[1]` high at counts 0,1 only (symmetric). `wrap` every 8 cycles.
- Mid-period write: P=9 running; at count 5 set `period`=4, ch0 compare=1 → current period still ends at 9. The next period is 0..4 with `flag[0]` high only at count 0.
- One-shot, edge, P=3 → counts 0,1,2,3, then `wrap`=`done`=1 for one cycle, `busy`=0, `flag`=`pol`. Further `start`=0 leaves the block in IDLE.
- Pause and stop: `en`=0 at count 6 for 5 cycles → count holds 6 and `flag` is stable. Then `stop` → IDLE next cycle with count 0, no `wrap`/`done`.
- Corners: compare=0 → flag always `pol[i]`. Compare=P+1 → always active. `pol[2]`=1 inverts ch2 only. `rst` asserted mid-run → all outputs at reset values next cycle.

Source files
------------

// File: rtl/pwm_timer_multi.sv
// Multi-channel PWM timer: one shared up/up-down counter and period, CHANNELS
// compare outputs, with period/compare shadows reloaded only at period ends.
module pwm_timer_multi #(
  parameter int WIDTH    = 24,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      en,
  input  logic                      center,
  input  logic                      oneshot,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] compare,
  input  logic [CHANNELS-1:0]       pol,
  output logic [WIDTH-1:0]          tmr_count,
  output logic [CHANNELS-1:0]       flag,
  output logic                      wrap,
  output logic                      done,
  output logic                      busy
);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] cmp_q [CHANNELS];
  logic [WIDTH-1:0] cmp_d [CHANNELS];
  logic             center_q, center_d;
  logic             oneshot_q, oneshot_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             eop;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_UP;
      cnt_q     <= '0;
      per_q     <= '0;
      center_q  <= 1'b0;
      oneshot_q <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
      // NOTE: the compare shadows are a small register file, not a RAM, so they
      // can be cleared on reset like any other flop.
      for (int i = 0; i < CHANNELS; i++) cmp_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the old
      // values of the others on this edge, regardless of statement order.
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      center_q  <= center_d;
      oneshot_q <= oneshot_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
      for (int i = 0; i < CHANNELS; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d   = state_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    center_d  = center_q;
    oneshot_d = oneshot_q;
    cmp_d     = cmp_q;
    wrap_d    = 1'b0;
    done_d    = 1'b0;
    eop       = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dir_d   = DIR_UP;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start) begin
            state_d   = S_RUN;
            dir_d     = DIR_UP;
            per_d     = period;
            center_d  = center;
            oneshot_d = oneshot;
            for (int i = 0; i < CHANNELS; i++) cmp_d[i] = compare[i*WIDTH +: WIDTH];
          end
        end
        S_RUN: begin
          if (en) begin
            if (!center_q) begin
              if (cnt_q == per_q) eop = 1'b1;
              else                cnt_d = cnt_q + ONE;
            end else if (dir_q == DIR_UP) begin
              // Center mode turns around at the top without repeating it.
              if (cnt_q == per_q) begin
                if (per_q <= ONE) begin
                  eop = 1'b1;
                end else begin
                  dir_d = DIR_DOWN;
                  cnt_d = per_q - ONE;
                end
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end else begin
              if (cnt_q == ONE) eop = 1'b1;
              else              cnt_d = cnt_q - ONE;
            end

            if (eop) begin
              cnt_d  = '0;
              dir_d  = DIR_UP;
              per_d  = period;
              wrap_d = 1'b1;
              for (int i = 0; i < CHANNELS; i++) cmp_d[i] = compare[i*WIDTH +: WIDTH];
              if (oneshot_q) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs: flags are combinational so polarity changes apply immediately.
  always_comb begin
    busy      = (state_q == S_RUN);
    tmr_count = cnt_q;
    wrap      = wrap_q;
    done      = done_q;
    for (int i = 0; i < CHANNELS; i++) begin
      flag[i] = busy ? ((cmp_q[i] > cnt_q) ^ pol[i]) : pol[i];
    end
  end

endmodule

// File: tb/tb_pwm_timer_multi.sv
// Scoreboard bench for pwm_timer_multi: a phase-based reference model pushes
// the expected outputs on every clock edge; each scenario pops and compares.
module tb_pwm_timer_multi;

  localparam int W = 24;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           rst, start, stop, en, center, oneshot;
  logic [W-1:0]   period;
  logic [C*W-1:0] compare;
  logic [C-1:0]   pol;
  logic [W-1:0]   tmr_count;
  logic [C-1:0]   flag;
  logic           wrap, done, busy;

  pwm_timer_multi #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
    .center(center), .oneshot(oneshot), .period(period), .compare(compare),
    .pol(pol), .tmr_count(tmr_count), .flag(flag), .wrap(wrap), .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic [C-1:0] flag;
    logic         wrap;
    logic         done;
    logic         busy;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: position within the period (phase) and period length.
  bit     m_run, m_center, m_oneshot, m_wrap, m_done;
  longint m_phase, m_p;
  longint m_cmp [C];

  function automatic longint m_len();
    if (m_center) return (m_p == 0) ? 64'sd1 : 2 * m_p;
    return m_p + 1;
  endfunction

  function automatic void m_load();
    m_p = longint'(period);
    for (int i = 0; i < C; i++) m_cmp[i] = longint'(compare[i*W +: W]);
  endfunction

  function automatic void m_step();
    m_wrap = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_phase = 0; m_p = 0; m_center = 1'b0; m_oneshot = 1'b0;
      for (int i = 0; i < C; i++) m_cmp[i] = 0;
    end else if (stop) begin
      m_run = 1'b0; m_phase = 0;
    end else if (!m_run) begin
      if (start) begin
        m_load();
        m_run = 1'b1; m_phase = 0; m_center = center; m_oneshot = oneshot;
      end
    end else if (en) begin
      if (m_phase + 1 == m_len()) begin
        m_phase = 0;
        m_wrap  = 1'b1;
        m_load();
        if (m_oneshot) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end else begin
        m_phase = m_phase + 1;
      end
    end
  endfunction

  function automatic obs_t m_out();
    obs_t   o;
    longint c;
    c = (m_center && m_phase > m_p) ? 2 * m_p - m_phase : m_phase;
    o.cnt  = W'(c);
    o.wrap = m_wrap;
    o.done = m_done;
    o.busy = m_run;
    for (int i = 0; i < C; i++) o.flag[i] = m_run ? ((m_cmp[i] > c) ^ pol[i]) : pol[i];
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.cnt = tmr_count; o.flag = flag; o.wrap = wrap; o.done = done; o.busy = busy;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("cnt=%0d flag=%b wrap=%b done=%b busy=%b", o.cnt, o.flag, o.wrap, o.done, o.busy);
  endfunction

  // One clock: model sees the same inputs as the DUT, then outputs settle.
  task automatic tick();
    @(posedge clk);
    m_step();
    exp_q.push_back(m_out());
    #1;
  endtask

  task automatic set_cmp(input int ch, input logic [W-1:0] v);
    compare[ch*W +: W] = v;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1;
    for (int t = 0; t < 2; t++) begin
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
    end
    n_cmp++;
    if (tmr_count !== '0 || busy !== 1'b0 || wrap !== 1'b0 || done !== 1'b0 || flag !== 4'b0000) begin
      n_err++; $display("FAIL reset_values: got %s want cnt=0 flag=0000 wrap=0 done=0 busy=0", fmt(sample()));
    end
    rst = 1'b0;
  endtask

  task automatic test_edge();
    obs_t o, e;
    int   highs, wraps;
    highs = 0; wraps = 0;
    center = 1'b0; oneshot = 1'b0; en = 1'b1; pol = '0;
    period = 24'd9; compare = '0; set_cmp(0, 24'd3);
    for (int t = 0; t < 30; t++) begin
      start = (t == 0);
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL edge t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
      if (t < 10 && flag[0]) highs++;
      if (wrap) wraps++;
    end
    start = 1'b0;
    n_cmp++;
    if (highs != 3) begin n_err++; $display("FAIL edge_duty: got %0d high cycles want 3", highs); end
    n_cmp++;
    if (wraps != 2) begin n_err++; $display("FAIL edge_wraps: got %0d want 2", wraps); end
    stop = 1'b1; tick(); stop = 1'b0;
    e = exp_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL edge_stop: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_center();
    obs_t o, e;
    int   highs, wraps;
    highs = 0; wraps = 0;
    center = 1'b1; period = 24'd4; compare = '0; set_cmp(1, 24'd2);
    for (int t = 0; t < 24; t++) begin
      start = (t == 0);
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL center t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
      if (t < 8 && flag[1]) highs++;
      if (wrap) wraps++;
    end
    start = 1'b0;
    n_cmp++;
    if (highs != 3) begin n_err++; $display("FAIL center_duty: got %0d high cycles want 3", highs); end
    n_cmp++;
    if (wraps != 2) begin n_err++; $display("FAIL center_wraps: got %0d want 2", wraps); end
    stop = 1'b1; tick(); stop = 1'b0; center = 1'b0;
    e = exp_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL center_stop: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_midwrite();
    obs_t o, e;
    int   wraps, highs;
    wraps = 0; highs = 0;
    period = 24'd9; compare = '0; set_cmp(0, 24'd5);
    for (int t = 0; t < 25; t++) begin
      start = (t == 0);
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL midwrite t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
      if (wrap) wraps++;
      if (t >= 10 && t < 15 && flag[0]) highs++;
      if (t == 5) begin period = 24'd4; set_cmp(0, 24'd1); end
    end
    start = 1'b0;
    n_cmp++;
    if (wraps != 3) begin n_err++; $display("FAIL midwrite_wraps: got %0d want 3", wraps); end
    n_cmp++;
    if (highs != 1) begin n_err++; $display("FAIL midwrite_duty: got %0d high cycles want 1", highs); end
    stop = 1'b1; tick(); stop = 1'b0;
    e = exp_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL midwrite_stop: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_oneshot();
    obs_t o, e;
    oneshot = 1'b1; period = 24'd3; pol = 4'b0101; compare = '0; set_cmp(0, 24'd2);
    for (int t = 0; t < 8; t++) begin
      start = (t == 0);
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL oneshot t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
      if (t == 4) begin
        n_cmp++;
        if (wrap !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || flag !== 4'b0101 || tmr_count !== '0) begin
          n_err++; $display("FAIL oneshot_end: got %s want cnt=0 flag=0101 wrap=1 done=1 busy=0", fmt(sample()));
        end
      end
    end
    start = 1'b0; oneshot = 1'b0; pol = '0;
  endtask

  task automatic test_pause_stop();
    obs_t       o, e;
    logic [C-1:0] held;
    period = 24'd9; compare = '0; set_cmp(0, 24'd4); set_cmp(3, 24'd7);
    for (int t = 0; t < 7; t++) begin
      start = (t == 0);
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL pause_run t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
    end
    start = 1'b0; held = flag; en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL pause t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
      n_cmp++;
      if (tmr_count !== 24'd6 || flag !== held) begin
        n_err++; $display("FAIL pause_hold t=%0d: got cnt=%0d flag=%b want cnt=6 flag=%b", t, tmr_count, flag, held);
      end
    end
    en = 1'b1; stop = 1'b1; tick(); stop = 1'b0;
    e = exp_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL stop: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (tmr_count !== '0 || wrap !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL stop_values: got %s want cnt=0 wrap=0 done=0 busy=0", fmt(sample()));
    end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    e = exp_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL start_and_stop: got %s want %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_p0_and_max();
    obs_t o, e;
    period = '0; compare = '0;
    for (int t = 0; t < 6; t++) begin
      start = (t == 0);
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL p0 t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
      n_cmp++;
      if (wrap !== (t > 0)) begin n_err++; $display("FAIL p0_wrap t=%0d: got %b want %b", t, wrap, (t > 0)); end
    end
    stop = 1'b1; tick(); stop = 1'b0; void'(exp_q.pop_front());
    period = '1; set_cmp(0, '1); set_cmp(2, 24'd3);
    for (int t = 0; t < 6; t++) begin
      start = (t == 0);
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL pmax t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
    end
    start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0; void'(exp_q.pop_front());
  endtask

  task automatic test_corners();
    obs_t o, e;
    period = 24'd5; compare = '0;
    set_cmp(0, 24'd0); set_cmp(1, 24'd6); set_cmp(2, 24'd3); set_cmp(3, 24'd5);
    pol = 4'b0100;
    for (int t = 0; t < 14; t++) begin
      start = (t == 0);
      if (t == 9) pol = 4'b0000;
      tick();
      e = exp_q.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL corners t=%0d: got %s want %s", t, fmt(o), fmt(e)); end
      n_cmp++;
      if (flag[0] !== 1'b0 || flag[1] !== 1'b1) begin
        n_err++; $display("FAIL corner_levels t=%0d: got flag=%b want flag[1:0]=10", t, flag);
      end
    end
    start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    e = exp_q.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_err++; $display("FAIL midrun_reset: got %s want %s", fmt(o), fmt(e)); end
    n_cmp++;
    if (tmr_count !== '0 || busy !== 1'b0 || wrap !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL midrun_reset_values: got %s want cnt=0 wrap=0 done=0 busy=0", fmt(sample()));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b1; center = 1'b0; oneshot = 1'b0;
    period = '0; compare = '0; pol = '0;
    m_run = 1'b0; m_phase = 0; m_p = 0; m_center = 1'b0; m_oneshot = 1'b0;
    m_wrap = 1'b0; m_done = 1'b0;
    for (int i = 0; i < C; i++) m_cmp[i] = 0;
    test_reset();
    test_edge();
    test_center();
    test_midwrite();
    test_oneshot();
    test_pause_stop();
    test_p0_and_max();
    test_corners();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
